genpad_poll_scheduler: RTL and testbench



---
 rtl/genpad_poll_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_genpad_poll_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/genpad_poll_scheduler.sv
// Two-port Genesis DB9 poll sequencer: runs the 8-phase SELECT protocol on port A then B,
// decodes through one shared sampler, commits each port atomically, then enforces a recovery gap.
module genpad_poll_scheduler #(
  parameter int unsigned PHASE_TICKS   = 500,
  parameter int unsigned SETTLE_TICKS  = 48,
  parameter int unsigned RECOVER_TICKS = 80000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iPOLL_REQ,
  input  logic [5:0]  iGENPAD_A,
  input  logic [5:0]  iGENPAD_B,
  output logic        oSELECT_A,
  output logic        oSELECT_B,
  output logic [11:0] oPAD_A,
  output logic [11:0] oPAD_B,
  output logic [1:0]  oTYPE_A,
  output logic [1:0]  oTYPE_B,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam int unsigned MAX_TICKS = (PHASE_TICKS > RECOVER_TICKS) ? PHASE_TICKS : RECOVER_TICKS;
  localparam int unsigned TW        = $clog2(MAX_TICKS);

  localparam logic [TW-1:0] PHASE_LAST   = TW'(PHASE_TICKS - 1);
  localparam logic [TW-1:0] SAMPLE_TICK  = TW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0] RECOVER_LAST = TW'(RECOVER_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RECOVER
  } state_e;

  state_e        state_q, state_d;
  logic          port_q, port_d;
  logic [2:0]    phase_q, phase_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          pending_q, pending_d;
  logic          sel_a_q, sel_a_d;
  logic          sel_b_q, sel_b_d;
  logic [11:0]   shadow_q, shadow_d;
  logic          t3_q, t3_d;
  logic          t6_q, t6_d;
  logic [11:0]   pad_a_q, pad_a_d;
  logic [11:0]   pad_b_q, pad_b_d;
  logic [1:0]    type_a_q, type_a_d;
  logic [1:0]    type_b_q, type_b_d;
  logic          done_q, done_d;

  logic [5:0]    pins;
  logic [1:0]    type_code;

  always_comb begin
    pins      = port_q ? iGENPAD_B : iGENPAD_A;
    type_code = t6_q ? 2'd2 : (t3_q ? 2'd1 : 2'd0);

    state_d   = state_q;
    port_d    = port_q;
    phase_d   = phase_q;
    tick_d    = tick_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    t3_d      = t3_q;
    t6_d      = t6_q;
    pad_a_d   = pad_a_q;
    pad_b_d   = pad_b_q;
    type_a_d  = type_a_q;
    type_b_d  = type_b_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iPOLL_REQ || pending_q) begin
          state_d   = ST_RUN;
          port_d    = 1'b0;
          phase_d   = 3'd0;
          tick_d    = '0;
          pending_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (iPOLL_REQ) begin
          pending_d = 1'b1;
        end

        // Clearing at the start of each sweep makes unsampled buttons read as released.
        if (phase_q == 3'd0 && tick_q == '0) begin
          shadow_d = '0;
          t3_d     = 1'b0;
          t6_d     = 1'b0;
        end

        if (tick_q == SAMPLE_TICK) begin
          case (phase_q)
            3'd0: begin
              shadow_d[3:0] = ~pins[3:0];
              shadow_d[5]   = ~pins[4];
              shadow_d[6]   = ~pins[5];
            end
            3'd1: begin
              t3_d = (pins[1:0] == 2'b00);
              if (pins[1:0] == 2'b00) begin
                shadow_d[4] = ~pins[4];
                shadow_d[7] = ~pins[5];
              end
            end
            3'd5: begin
              t6_d = t3_q && (pins[3:0] == 4'b0000);
            end
            3'd6: begin
              if (t6_q) begin
                shadow_d[11:8] = ~pins[3:0];
              end
            end
            default: ;
          endcase
        end

        if (tick_q == PHASE_LAST) begin
          tick_d  = '0;
          phase_d = phase_q + 3'd1;
          if (phase_q == 3'd7) begin
            if (!port_q) begin
              pad_a_d  = shadow_q;
              type_a_d = type_code;
              port_d   = 1'b1;
            end else begin
              pad_b_d  = shadow_q;
              type_b_d = type_code;
              done_d   = 1'b1;
              state_d  = ST_RECOVER;
            end
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      ST_RECOVER: begin
        if (iPOLL_REQ) begin
          pending_d = 1'b1;
        end
        if (tick_q == RECOVER_LAST) begin
          tick_d = '0;
          if (pending_q || iPOLL_REQ) begin
            state_d   = ST_RUN;
            port_d    = 1'b0;
            phase_d   = 3'd0;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // SELECT is derived from the next state so the registered line moves with the phase boundary.
    sel_a_d = 1'b1;
    sel_b_d = 1'b1;
    if (state_d == ST_RUN) begin
      if (port_d) begin
        sel_b_d = ~phase_d[0];
      end else begin
        sel_a_d = ~phase_d[0];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= ST_IDLE;
      port_q    <= 1'b0;
      phase_q   <= 3'd0;
      tick_q    <= '0;
      pending_q <= 1'b0;
      sel_a_q   <= 1'b1;
      sel_b_q   <= 1'b1;
      shadow_q  <= '0;
      t3_q      <= 1'b0;
      t6_q      <= 1'b0;
      pad_a_q   <= '0;
      pad_b_q   <= '0;
      type_a_q  <= '0;
      type_b_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      shadow_q  <= shadow_d;
      t3_q      <= t3_d;
      t6_q      <= t6_d;
      pad_a_q   <= pad_a_d;
      pad_b_q   <= pad_b_d;
      type_a_q  <= type_a_d;
      type_b_q  <= type_b_d;
      done_q    <= done_d;
    end
  end

  assign oSELECT_A = sel_a_q;
  assign oSELECT_B = sel_b_q;
  assign oPAD_A    = pad_a_q;
  assign oPAD_B    = pad_b_q;
  assign oTYPE_A   = type_a_q;
  assign oTYPE_B   = type_b_q;
  assign oBUSY     = (state_q != ST_IDLE);
  assign oDONE     = done_q;

endmodule

// File: tb/tb_genpad_poll_scheduler.sv
// Bench for genpad_poll_scheduler: behavioural pad models on both ports, cycle-exact
// expectations from the poll timing formulas, randomized pad types, buttons and extra requests.
module tb_genpad_poll_scheduler;

  localparam int P = 8;
  localparam int S = 3;
  localparam int R = 20;
  localparam int T = 16 * P + R;

  logic        clk;
  logic        rst;
  logic        req;
  logic [5:0]  pin_a, pin_b;
  logic        sel_a, sel_b;
  logic [11:0] pad_a, pad_b;
  logic [1:0]  typ_a, typ_b;
  logic        busy, done;

  int n_vec = 0;
  int n_err = 0;

  // pad types: 0 open, 1 MasterSystem, 2 three-button, 3 six-button
  int          type_a = 0, type_b = 0;
  logic [11:0] btn_a = '0, btn_b = '0;
  int          cnt_a = 0, cnt_b = 0, idle_a = 0, idle_b = 0;
  logic        prev_a = 1'b1, prev_b = 1'b1;
  logic [11:0] last_pad_a = '0, last_pad_b = '0;
  logic [1:0]  last_type_a = '0, last_type_b = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genpad_poll_scheduler #(
    .PHASE_TICKS  (P),
    .SETTLE_TICKS (S),
    .RECOVER_TICKS(R)
  ) dut (
    .iCLK      (clk),
    .iRESET    (rst),
    .iPOLL_REQ (req),
    .iGENPAD_A (pin_a),
    .iGENPAD_B (pin_b),
    .oSELECT_A (sel_a),
    .oSELECT_B (sel_b),
    .oPAD_A    (pad_a),
    .oPAD_B    (pad_b),
    .oTYPE_A   (typ_a),
    .oTYPE_B   (typ_b),
    .oBUSY     (busy),
    .oDONE     (done)
  );

  function automatic logic [5:0] pad_pins(int ty, logic [11:0] m, int ph, logic sel);
    logic z, y, x, md, s, c, b, a, u, d, l, r;
    {z, y, x, md, s, c, b, a, u, d, l, r} = m;
    case (ty)
      1: return ~{c, b, u, d, l, r};
      2: return sel ? ~{c, b, u, d, l, r} : {~s, ~a, ~u, ~d, 2'b00};
      3: begin
        if (sel) return (ph == 6) ? ~{c, b, z, y, x, md} : ~{c, b, u, d, l, r};
        else if (ph == 5) return {~s, ~a, 4'b0000};
        else if (ph == 7) return {~s, ~a, 4'b1111};
        else return {~s, ~a, ~u, ~d, 2'b00};
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign pin_a = pad_pins(type_a, btn_a, cnt_a, sel_a);
  assign pin_b = pad_pins(type_b, btn_b, cnt_b, sel_b);

  // Pads count SELECT edges and fall back to phase 0 after a quiet spell.
  always @(negedge clk) begin
    if (sel_a != prev_a) begin cnt_a <= cnt_a + 1; idle_a <= 0; end
    else if (idle_a >= 2 * P) cnt_a <= 0;
    else idle_a <= idle_a + 1;
    prev_a <= sel_a;
    if (sel_b != prev_b) begin cnt_b <= cnt_b + 1; idle_b <= 0; end
    else if (idle_b >= 2 * P) cnt_b <= 0;
    else idle_b <= idle_b + 1;
    prev_b <= sel_b;
  end

  function automatic logic [11:0] exp_pad(int ty, logic [11:0] m);
    case (ty)
      1: return m & 12'h06F;
      2: return m & 12'h0FF;
      3: return m;
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] exp_type(int ty);
    case (ty)
      2: return 2'd1;
      3: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] m;
    m = 12'($urandom);
    if (m[3]) m[2] = 1'b0;
    if (m[1]) m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_sel_a"}, 32'(sel_a), 32'd1);
    check_eq({tag, "_sel_b"}, 32'(sel_b), 32'd1);
    check_eq({tag, "_pad_a"}, 32'(pad_a), 32'd0);
    check_eq({tag, "_pad_b"}, 32'(pad_b), 32'd0);
    check_eq({tag, "_type_a"}, 32'(typ_a), 32'd0);
    check_eq({tag, "_type_b"}, 32'(typ_b), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One request in cycle 0, optional extra request pulses in cycles p1..p3 (<=0 means none).
  task automatic run_window(input int p1, input int p2, input int p3);
    logic [11:0] ea, eb;
    logic [1:0]  eta, etb;
    int          npolls, kk, j;
    bit          act;
    npolls = (p1 > 0 || p2 > 0 || p3 > 0) ? 2 : 1;
    ea  = exp_pad(type_a, btn_a);
    eb  = exp_pad(type_b, btn_b);
    eta = exp_type(type_a);
    etb = exp_type(type_b);
    @(negedge clk);
    req = 1'b1;
    for (int k = 1; k <= npolls * T + 6; k++) begin
      @(posedge clk);
      #1;
      req = (k == p1 || k == p2 || k == p3);
      kk  = (k - 1) % T;
      j   = (k - 1) / T;
      act = (j < npolls);
      check_eq("busy", 32'(busy), 32'(k < 1 + npolls * T));
      check_eq("sel_a", 32'(sel_a), 32'(!(act && kk < 8 * P && (kk / P) % 2 == 1)));
      check_eq("sel_b", 32'(sel_b),
               32'(!(act && kk >= 8 * P && kk < 16 * P && ((kk - 8 * P) / P) % 2 == 1)));
      check_eq("done", 32'(done), 32'(act && kk == 16 * P));
      check_eq("pad_a", 32'(pad_a), 32'((k >= 1 + 8 * P) ? ea : last_pad_a));
      check_eq("type_a", 32'(typ_a), 32'((k >= 1 + 8 * P) ? eta : last_type_a));
      check_eq("pad_b", 32'(pad_b), 32'((k >= 1 + 16 * P) ? eb : last_pad_b));
      check_eq("type_b", 32'(typ_b), 32'((k >= 1 + 16 * P) ? etb : last_type_b));
    end
    req         = 1'b0;
    last_pad_a  = ea;
    last_pad_b  = eb;
    last_type_a = eta;
    last_type_b = etb;
    repeat (2 * P + 4) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // 3-button, Start + Up on A; B open
    type_a = 2; btn_a = 12'h088; type_b = 0; btn_b = '0;
    run_window(-1, -1, -1);

    // A open, 6-button on B with X + Mode
    type_a = 0; btn_a = 12'hFFF; type_b = 3; btn_b = 12'h300;
    run_window(-1, -1, -1);

    // MasterSystem on A: buttons 1+2 and Left
    type_a = 1; btn_a = 12'h062; type_b = 2; btn_b = 12'h0C5;
    run_window(-1, -1, -1);

    // three extra requests during RUN and RECOVER collapse into one back-to-back poll
    type_a = 3; btn_a = 12'hA59; type_b = 1; btn_b = 12'h066;
    run_window(10, 60, 140);

    // reset in port B phase 3
    type_a = 2; btn_a = 12'h0A9; type_b = 3; btn_b = 12'h5C4;
    @(negedge clk);
    req = 1'b1;
    for (int k = 1; k <= 1 + 11 * P + 2; k++) begin
      @(posedge clk);
      #1;
      req = 1'b0;
    end
    check_eq("pre_reset_pad_a", 32'(pad_a), 32'(exp_pad(type_a, btn_a)));
    rst = 1'b1;
    #1;
    check_reset_values("midpoll_reset");
    @(negedge clk);
    rst = 1'b0;
    last_pad_a = '0; last_pad_b = '0; last_type_a = '0; last_type_b = '0;
    repeat (2 * P + 4) @(posedge clk);
    run_window(-1, -1, -1);

    for (int it = 0; it < 16; it++) begin
      type_a = int'($urandom_range(0, 3));
      type_b = int'($urandom_range(0, 3));
      btn_a  = rand_btn();
      btn_b  = rand_btn();
      if ($urandom_range(0, 1) == 1)
        run_window(int'($urandom_range(1, T)), -1, -1);
      else
        run_window(-1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
